seg7_scan_reader: RTL and testbench
===================================

Name: seg7_scan_reader

Overview:
- Receive-side counterpart of the team's BCD-to-7-segment decoder.
- Observes a time-multiplexed 7-segment display bus (segment lines plus one-hot digit selects) and reconstructs the BCD digits being shown.
- Sits in the display verification/loopback path: display driver outputs feed in, recovered digits go out as a parallel bus.
- Filters glitches with a stability counter, collects one complete frame of digits, and publishes all digits atomically with a one-cycle strobe.

Parameters:
- N_DIG, 4, number of multiplexed digits (≥2)
- STABLE, 4, consecutive identical samples required before a digit is captured (2..255)
- CNT_W, 8, width of the stability counter (must hold STABLE)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- seg_in  input  7  segment levels, active-high, {a,b,c,d,e,f,g}, a = MSB
- dig_sel  input  N_DIG  digit enables, active-high, one-hot; bit i = digit i
- bcd_out  output  4*N_DIG  recovered digits; digit i at bits [4i+3:4i]
- err_out  output  N_DIG  digit i pattern was not a legal code
- blank_out  output  N_DIG  digit i pattern was all-off (0x00)
- frame_valid  output  1  one-cycle pulse when outputs update
- sel_err  output  1  one-cycle pulse on a new non-zero, non-one-hot dig_sel sample

Behaviour:
- Reset (async, rst_n=0):
  - bcd_out=0, err_out=0, blank_out=0, frame_valid=0, sel_err=0.
  - Sample register, counter, capture mask and shadow registers cleared.
  - FSM goes to IDLE.
- Sampling: {dig_sel, seg_in} is registered into smp on every edge.
  - If the new sample differs from smp: cnt=1.
  - Otherwise: cnt increments, saturating at STABLE.
- Legal codes (seg_in → BCD): 7E→0, 30→1, 6D→2, 79→3, 33→4, 5B→5, 5F→6, 70→7, 7F→8, 7B→9.
  - 00: BCD=0, blank=1, err=0.
  - Any other pattern: BCD=F, err=1, blank=0.
- FSM:
  - IDLE: sampled dig_sel is zero or not one-hot.
    - Go to SETTLE when a one-hot sample arrives.
    - A non-one-hot, non-zero sample that differs from the previous sample pulses sel_err for 1 cycle.
  - SETTLE: counting.
    - On the edge where cnt becomes STABLE: decode the sample, write shadow[i] (BCD, err, blank), set mask[i], go to HOLD.
    - Sample change: cnt=1; stay in SETTLE if still one-hot, else go to IDLE.
  - HOLD: digit already captured for this dwell; no recapture while the sample is unchanged.
    - Any change: go to SETTLE (one-hot) or IDLE.
- Latency: a value first sampled at edge k is captured at edge k+STABLE-1.
- Frame publish:
  - On the capture edge that makes mask all ones, copy shadow (including the just-captured digit) to bcd_out/err_out/blank_out.
  - At the same time, pulse frame_valid for exactly one cycle and clear mask.
  - Outputs hold between frames.
- Repeat capture of a digit already in the mask before the frame completes overwrites shadow[i] (latest wins); the mask is unchanged.
- Segment glitch shorter than STABLE samples: no capture, and no capture of the glitch value.
- Reset mid-frame: partial mask and shadow are discarded; the first frame after reset needs all N_DIG digits.
- STABLE=1 is illegal; the implementation may assert it.

Test Plan:
- Reset → all outputs 0. Drive digits 0..3 with dig_sel 0001,0010,0100,1000 and seg 7E,30,6D,79, each held 6 cycles → frame_valid single pulse 3 cycles into the dwell of digit 3, bcd_out=16'h3210, err_out=0, blank_out=0.
- Digit 1 seg=30 held only 3 cycles (STABLE=4), then 5B held 6 cycles, other digits legal → bcd_out[7:4]=5; no capture of 1.
- seg=0x00 on digit 2 and seg=0x49 on digit 3 → blank_out=4'b0100, err_out=4'b1000, bcd_out[15:12]=F, bcd_out[11:8]=0.
- dig_sel=0011 for 5 cycles mid-scan → sel_err pulses once; no capture; mask unaffected; the frame completes normally afterwards.
- Digit 0 captured as 8 (7F), then recaptured as 9 (7B) before digits 1-3 → published digit 0=9 and exactly one frame_valid.
- rst_n low for 1 cycle after digits 0-2 captured → no frame_valid until all four digits are recaptured; outputs read 0 meanwhile.

Source files
------------

// File: rtl/seg7_scan_reader_if.sv
// Multiplexed 7-segment bus in, recovered parallel digits out.
interface seg7_scan_reader_if #(
  parameter int N_DIG = 4
);
  logic [6:0]         seg_in;
  logic [N_DIG-1:0]   dig_sel;
  logic [4*N_DIG-1:0] bcd_out;
  logic [N_DIG-1:0]   err_out;
  logic [N_DIG-1:0]   blank_out;
  logic               frame_valid;
  logic               sel_err;

  modport master (
    output seg_in, dig_sel,
    input  bcd_out, err_out, blank_out, frame_valid, sel_err
  );

  modport slave (
    input  seg_in, dig_sel,
    output bcd_out, err_out, blank_out, frame_valid, sel_err
  );
endinterface

// File: rtl/seg7_scan_reader.sv
// Rebuilds BCD digits from a scanned 7-segment display bus. Each digit must
// hold steady for STABLE samples before capture; a full frame publishes at once.
module seg7_scan_reader #(
  parameter int N_DIG  = 4,
  parameter int STABLE = 4,
  parameter int CNT_W  = 8
) (
  input logic               clk,
  input logic               rst_n,
  seg7_scan_reader_if.slave bus
);
  localparam int SW = N_DIG + 7;
  localparam logic [CNT_W-1:0] STB    = CNT_W'(STABLE);
  localparam logic [CNT_W-1:0] STB_M1 = CNT_W'(STABLE - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t                 st_q, st_d;
  logic [SW-1:0]          smp_q, smp_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [N_DIG-1:0]       mask_q, mask_d;
  logic [N_DIG-1:0][3:0]  shd_bcd_q, shd_bcd_d;
  logic [N_DIG-1:0]       shd_err_q, shd_err_d;
  logic [N_DIG-1:0]       shd_blk_q, shd_blk_d;
  logic [N_DIG-1:0][3:0]  bcd_q, bcd_d;
  logic [N_DIG-1:0]       err_q, err_d;
  logic [N_DIG-1:0]       blk_q, blk_d;
  logic                   fv_q, fv_d;
  logic                   se_q, se_d;

  logic                   changed, new_oh, capture;
  logic [N_DIG-1:0]       cap_sel, mask_set;
  logic [5:0]             dec;

  // {err, blank, bcd}
  function automatic logic [5:0] dec7(input logic [6:0] s);
    case (s)
      7'h7E:   dec7 = 6'h00;
      7'h30:   dec7 = 6'h01;
      7'h6D:   dec7 = 6'h02;
      7'h79:   dec7 = 6'h03;
      7'h33:   dec7 = 6'h04;
      7'h5B:   dec7 = 6'h05;
      7'h5F:   dec7 = 6'h06;
      7'h70:   dec7 = 6'h07;
      7'h7F:   dec7 = 6'h08;
      7'h7B:   dec7 = 6'h09;
      7'h00:   dec7 = 6'h10;
      default: dec7 = 6'h2F;
    endcase
  endfunction

  always_comb begin
    smp_d   = {bus.dig_sel, bus.seg_in};
    changed = (smp_d != smp_q);
    new_oh  = $onehot(bus.dig_sel);
    cap_sel = smp_q[SW-1:7];
    dec     = dec7(smp_q[6:0]);
    cnt_d   = changed ? CNT_W'(1) : ((cnt_q == STB) ? cnt_q : cnt_q + 1'b1);
    se_d    = changed && (bus.dig_sel != '0) && !new_oh;
    st_d    = st_q;
    capture = 1'b0;

    case (st_q)
      IDLE:   if (new_oh) st_d = SETTLE;
      SETTLE: begin
        if (changed) st_d = new_oh ? SETTLE : IDLE;
        else if (cnt_q == STB_M1) begin
          // the counter reaches STABLE on this edge
          capture = 1'b1;
          st_d    = HOLD;
        end
      end
      HOLD:   if (changed) st_d = new_oh ? SETTLE : IDLE;
      default: st_d = IDLE;
    endcase

    shd_bcd_d = shd_bcd_q;
    shd_err_d = shd_err_q;
    shd_blk_d = shd_blk_q;
    mask_d    = mask_q;
    mask_set  = mask_q | cap_sel;
    bcd_d     = bcd_q;
    err_d     = err_q;
    blk_d     = blk_q;
    fv_d      = 1'b0;

    if (capture) begin
      for (int i = 0; i < N_DIG; i++) begin
        if (cap_sel[i]) begin
          shd_bcd_d[i] = dec[3:0];
          shd_blk_d[i] = dec[4];
          shd_err_d[i] = dec[5];
        end
      end
      if (&mask_set) begin
        bcd_d  = shd_bcd_d;
        err_d  = shd_err_d;
        blk_d  = shd_blk_d;
        fv_d   = 1'b1;
        mask_d = '0;
      end else begin
        mask_d = mask_set;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= IDLE;
      smp_q     <= '0;
      cnt_q     <= '0;
      mask_q    <= '0;
      shd_bcd_q <= '0;
      shd_err_q <= '0;
      shd_blk_q <= '0;
      bcd_q     <= '0;
      err_q     <= '0;
      blk_q     <= '0;
      fv_q      <= 1'b0;
      se_q      <= 1'b0;
    end else begin
      st_q      <= st_d;
      smp_q     <= smp_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      shd_bcd_q <= shd_bcd_d;
      shd_err_q <= shd_err_d;
      shd_blk_q <= shd_blk_d;
      bcd_q     <= bcd_d;
      err_q     <= err_d;
      blk_q     <= blk_d;
      fv_q      <= fv_d;
      se_q      <= se_d;
    end
  end

  assign bus.bcd_out     = bcd_q;
  assign bus.err_out     = err_q;
  assign bus.blank_out   = blk_q;
  assign bus.frame_valid = fv_q;
  assign bus.sel_err     = se_q;
endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed plan scenarios then random scanning, checked every cycle against
// a run-length model of the display bus.
module tb_seg7_scan_reader;
  localparam int N_DIG  = 4;
  localparam int STABLE = 4;

  logic gclk = 1'b0;
  logic rst_n;
  always #5 gclk = ~gclk;

  seg7_scan_reader_if #(.N_DIG(N_DIG)) bus ();

  seg7_scan_reader #(.N_DIG(N_DIG), .STABLE(STABLE), .CNT_W(8)) dut (
    .clk   (gclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [6:0] codes [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                             7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

  // model state
  logic [10:0]      m_prev;
  int               m_run;
  logic [3:0]       m_mask;
  logic [3:0]       s_bcd [4];
  logic [3:0]       s_err, s_blk;
  logic [15:0]      e_bcd;
  logic [3:0]       e_err, e_blk;
  logic             e_fv, e_se;

  int fv_cnt, se_cnt, fv_at;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] ref_dec(input logic [6:0] s);
    for (int k = 0; k < 10; k++)
      if (codes[k] == s) return {2'b00, 4'(k)};
    if (s == 7'h00) return 6'h10;
    return 6'h2F;
  endfunction

  task automatic model_reset();
    m_prev = '0; m_run = 0; m_mask = '0;
    for (int k = 0; k < 4; k++) s_bcd[k] = '0;
    s_err = '0; s_blk = '0;
    e_bcd = '0; e_err = '0; e_blk = '0; e_fv = 0; e_se = 0;
  endtask

  // A digit is captured on the edge where its sample has been seen STABLE times in a row.
  task automatic model_edge(input logic [3:0] sel, input logic [6:0] seg);
    logic [10:0] s;
    logic [5:0]  d;
    int idx;
    s = {sel, seg};
    e_se = (s != m_prev) && (sel != 0) && !$onehot(sel);
    m_run = (s != m_prev) ? 1 : m_run + 1;
    e_fv = 0;
    if (m_run == STABLE && $onehot(sel)) begin
      idx = 0;
      for (int k = 0; k < 4; k++) if (sel[k]) idx = k;
      d = ref_dec(seg);
      s_bcd[idx] = d[3:0];
      s_blk[idx] = d[4];
      s_err[idx] = d[5];
      m_mask[idx] = 1'b1;
      if (m_mask == 4'hF) begin
        e_bcd = {s_bcd[3], s_bcd[2], s_bcd[1], s_bcd[0]};
        e_err = s_err;
        e_blk = s_blk;
        e_fv  = 1;
        m_mask = '0;
      end
    end
    m_prev = s;
  endtask

  task automatic check_all();
    chk("bcd_out",     32'(bus.bcd_out),     32'(e_bcd));
    chk("err_out",     32'(bus.err_out),     32'(e_err));
    chk("blank_out",   32'(bus.blank_out),   32'(e_blk));
    chk("frame_valid", 32'(bus.frame_valid), 32'(e_fv));
    chk("sel_err",     32'(bus.sel_err),     32'(e_se));
  endtask

  task automatic drive(input logic [3:0] sel, input logic [6:0] seg, input int n);
    for (int j = 0; j < n; j++) begin
      bus.dig_sel = sel;
      bus.seg_in  = seg;
      @(posedge gclk);
      model_edge(sel, seg);
      #1;
      check_all();
      if (bus.frame_valid === 1'b1) begin fv_cnt++; fv_at = j; end
      if (bus.sel_err === 1'b1) se_cnt++;
    end
  endtask

  task automatic clr_cnt();
    fv_cnt = 0; se_cnt = 0; fv_at = -1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge gclk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] rsel;
    logic [6:0] rseg;
    int r;
    bus.dig_sel = '0;
    bus.seg_in  = '0;
    rst_n = 1'b0;
    model_reset();
    #12;
    check_all();
    rst_n = 1'b1;

    // plain frame 3,2,1,0
    clr_cnt();
    drive(4'b0001, 7'h7E, 6); drive(4'b0010, 7'h30, 6);
    drive(4'b0100, 7'h6D, 6);
    fv_at = -1;
    drive(4'b1000, 7'h79, 6);
    chk("t1_fv_cnt", fv_cnt, 1);
    chk("t1_fv_pos", fv_at, 3);
    chk("t1_bcd", 32'(bus.bcd_out), 32'h3210);

    // short glitch on digit 1 is never captured
    clr_cnt();
    drive(4'b0001, 7'h7E, 6); drive(4'b0010, 7'h30, 3); drive(4'b0010, 7'h5B, 6);
    drive(4'b0100, 7'h6D, 6); drive(4'b1000, 7'h79, 6);
    chk("t2_fv_cnt", fv_cnt, 1);
    chk("t2_bcd", 32'(bus.bcd_out), 32'h3250);

    // blank and illegal patterns
    clr_cnt();
    drive(4'b0001, 7'h7E, 6); drive(4'b0010, 7'h30, 6);
    drive(4'b0100, 7'h00, 6); drive(4'b1000, 7'h49, 6);
    chk("t3_blank", 32'(bus.blank_out), 32'h4);
    chk("t3_err",   32'(bus.err_out),   32'h8);
    chk("t3_bcd",   32'(bus.bcd_out),   32'hF010);

    // non-one-hot select mid-scan
    clr_cnt();
    drive(4'b0001, 7'h7E, 6); drive(4'b0010, 7'h30, 6); drive(4'b0011, 7'h30, 5);
    drive(4'b0100, 7'h6D, 6); drive(4'b1000, 7'h79, 6);
    chk("t4_se_cnt", se_cnt, 1);
    chk("t4_fv_cnt", fv_cnt, 1);
    chk("t4_bcd", 32'(bus.bcd_out), 32'h3210);

    // recapture of digit 0 before frame completes
    clr_cnt();
    drive(4'b0001, 7'h7F, 6); drive(4'b0001, 7'h7B, 6); drive(4'b0010, 7'h30, 6);
    drive(4'b0100, 7'h6D, 6); drive(4'b1000, 7'h79, 6);
    chk("t5_fv_cnt", fv_cnt, 1);
    chk("t5_bcd", 32'(bus.bcd_out), 32'h3219);

    // reset mid-frame discards partial capture
    clr_cnt();
    drive(4'b0001, 7'h7E, 6); drive(4'b0010, 7'h30, 6); drive(4'b0100, 7'h6D, 6);
    pulse_reset();
    drive(4'b1000, 7'h79, 6);
    chk("t6_fv_none", fv_cnt, 0);
    chk("t6_bcd_zero", 32'(bus.bcd_out), 32'h0);
    drive(4'b0001, 7'h33, 6); drive(4'b0010, 7'h5F, 6);
    drive(4'b0100, 7'h70, 6); drive(4'b1000, 7'h79, 6);
    chk("t6_fv_cnt", fv_cnt, 1);
    chk("t6_bcd", 32'(bus.bcd_out), 32'h3764);

    // random scanning with glitches, blanks, illegal codes and bad selects
    clr_cnt();
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 19);
      rsel = 4'b0001 << $urandom_range(0, 3);
      if (r == 0) rsel = 4'($urandom_range(0, 15));
      rseg = codes[$urandom_range(0, 9)];
      if (r == 1) rseg = 7'h00;
      if (r == 2) rseg = 7'($urandom_range(0, 127));
      drive(rsel, rseg, $urandom_range(1, 7));
    end
    chk("rnd_frames_seen", 32'(fv_cnt > 0), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
